// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: board front end for the 3-bit ALU core.
// Collects A, B and the op code from switches (one debounced button press
// per field), drives them to the core, waits out its register latency and
// holds the returned result/carry for the display logic.
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       bbclk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic [1:0] op_sw,
    input  logic       btn_n,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [5:0] alu_result,
    input  logic       alu_carry,
    output logic [5:0] result,
    output logic       carry,
    output logic       result_valid,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'b000,
        LOAD_B  = 3'b001,
        LOAD_OP = 3'b010,
        EXEC1   = 3'b011,
        EXEC2   = 3'b100,
        SHOW    = 3'b101
    } st_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_M1  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Counter that sticks at the debounce threshold so a held button
    // produces only one press.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= DEB_MAX) ? DEB_MAX : c + CNT_W'(1);
    endfunction

    logic             btn_p0, btn_p1;
    logic [2:0]       sw_p0, sw_p1;
    logic [1:0]       op_p0, op_p1;
    logic [CNT_W-1:0] deb_cnt;
    logic             press_pulse;

    st_t  cur_st, nxt_st;
    logic ld_a, ld_b, ld_op, cap, clr;

    assign state = cur_st;

    // Two-flop synchronisers for the button and both switch banks.
    always_ff @(posedge bbclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
            sw_p0  <= '0;
            sw_p1  <= '0;
            op_p0  <= '0;
            op_p1  <= '0;
        end else begin
            btn_p0 <= btn_n;
            btn_p1 <= btn_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            op_p0  <= op_sw;
            op_p1  <= op_p0;
        end
    end

    // Debounce: count stable-low cycles; pulse once on reaching the threshold.
    always_ff @(posedge bbclk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            press_pulse <= 1'b0;
        end else begin
            if (btn_p1) begin
                deb_cnt     <= '0;
                press_pulse <= 1'b0;
            end else begin
                deb_cnt     <= sat_inc(deb_cnt);
                press_pulse <= (deb_cnt == DEB_M1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge bbclk or negedge rst_n) begin
        if (!rst_n) cur_st <= LOAD_A;
        else        cur_st <= nxt_st;
    end

    // Next-state and load/capture strobes; presses in EXEC1/EXEC2 are ignored.
    always_comb begin
        nxt_st = cur_st;
        ld_a   = 1'b0;
        ld_b   = 1'b0;
        ld_op  = 1'b0;
        cap    = 1'b0;
        clr    = 1'b0;
        case (cur_st)
            LOAD_A: if (press_pulse) begin
                ld_a   = 1'b1;
                nxt_st = LOAD_B;
            end
            LOAD_B: if (press_pulse) begin
                ld_b   = 1'b1;
                nxt_st = LOAD_OP;
            end
            LOAD_OP: if (press_pulse) begin
                ld_op  = 1'b1;
                nxt_st = EXEC1;
            end
            EXEC1: nxt_st = EXEC2;
            EXEC2: begin
                cap    = 1'b1;
                nxt_st = SHOW;
            end
            SHOW: if (press_pulse) begin
                clr    = 1'b1;
                nxt_st = LOAD_A;
            end
            default: nxt_st = LOAD_A;
        endcase
    end

    // Operand/op registers to the core and held result registers.
    // Carry is only meaningful for ADD; the core leaves it stale otherwise.
    always_ff @(posedge bbclk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            result       <= '0;
            carry        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (ld_a)  alu_a  <= sw_p1;
            if (ld_b)  alu_b  <= sw_p1;
            if (ld_op) alu_op <= op_p1;
            if (cap) begin
                result       <= alu_result;
                carry        <= (alu_op == 2'b10) ? alu_carry : 1'b0;
                result_valid <= 1'b1;
            end else if (clr) begin
                result       <= '0;
                carry        <= 1'b0;
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU core attached.
module tb_alu_op_sequencer;

    logic       bbclk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = '0;
    logic [1:0] op_sw = '0;
    logic       btn_n = 1'b1;
    logic [2:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [5:0] alu_result;
    logic       alu_carry;
    logic [5:0] result;
    logic       carry;
    logic       result_valid;
    logic [2:0] state;

    int n_cmp = 0;
    int n_mis = 0;
    int n_trans = 0;
    logic [2:0] prev_st = '0;

    always #5 bbclk = ~bbclk;

    alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .bbclk(bbclk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw), .btn_n(btn_n),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .result(result), .carry(carry), .result_valid(result_valid),
        .state(state)
    );

    // ALU core: one register stage; carry only updated by ADD.
    always @(posedge bbclk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_carry  <= 1'b0;
        end else begin
            case (alu_op)
                2'b00: alu_result <= {3'b000, alu_a & alu_b};
                2'b01: alu_result <= {3'b000, alu_a | alu_b};
                2'b10: begin
                    alu_result <= 6'(int'(alu_a) + int'(alu_b));
                    alu_carry  <= (int'(alu_a) + int'(alu_b)) > 7;
                end
                default: alu_result <= 6'(int'(alu_a) * int'(alu_b));
            endcase
        end
    end

    // Count state changes for the no-repeat check.
    always @(negedge bbclk) begin
        if (state != prev_st) n_trans++;
        prev_st <= state;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_result(input int a, input int b, input int op);
        case (op)
            0: return 6'(a & b);
            1: return 6'(a | b);
            2: return 6'(a + b);
            default: return 6'(a * b);
        endcase
    endfunction

    function automatic logic ref_carry(input int a, input int b, input int op);
        return (op == 2) && (a + b > 7);
    endfunction

    task automatic apply_reset();
        @(negedge bbclk);
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (2) @(negedge bbclk);
        rst_n = 1'b1;
        repeat (3) @(negedge bbclk);
    endtask

    // Optional bounce, then hold low until the FSM moves (bounded).
    task automatic press_step(input int bounce);
        logic [2:0] s0;
        bit ok;
        for (int i = 0; i < bounce; i++) begin
            @(negedge bbclk);
            btn_n = ~btn_n;
        end
        @(negedge bbclk);
        btn_n = 1'b0;
        s0 = state;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge bbclk);
            if (state != s0) ok = 1;
        end
        if (!ok) chk("press_timeout", 0, 1);
    endtask

    task automatic release_btn();
        @(negedge bbclk);
        btn_n = 1'b1;
        repeat (3) @(negedge bbclk);
    endtask

    task automatic run_op(input int a, input int b, input int op, input int bounce, input bit inject);
        sw = 3'(a);
        repeat (3) @(negedge bbclk);
        press_step(bounce);
        chk("st_load_b", state, 1);
        chk("alu_a", alu_a, a);
        release_btn();
        sw = 3'($urandom);
        repeat (2) @(negedge bbclk);
        sw = 3'(b);
        repeat (3) @(negedge bbclk);
        press_step(bounce);
        chk("st_load_op", state, 2);
        chk("alu_b", alu_b, b);
        chk("alu_a_hold1", alu_a, a);
        release_btn();
        sw = 3'($urandom);
        op_sw = 2'(op);
        repeat (3) @(negedge bbclk);
        press_step(bounce);
        chk("st_exec1", state, 3);
        chk("alu_op", alu_op, op);
        chk("valid_exec1", result_valid, 0);
        if (inject) force dut.press_pulse = 1'b1;
        @(negedge bbclk);
        if (inject) release dut.press_pulse;
        chk("st_exec2", state, 4);
        chk("valid_exec2", result_valid, 0);
        @(negedge bbclk);
        chk("st_show", state, 5);
        chk("valid_show", result_valid, 1);
        chk("result", result, ref_result(a, b, op));
        chk("carry", carry, ref_carry(a, b, op));
        release_btn();
        chk("st_show_hold", state, 5);
        chk("valid_hold", result_valid, 1);
        chk("result_hold", result, ref_result(a, b, op));
        chk("alu_a_hold2", alu_a, a);
        chk("alu_b_hold", alu_b, b);
        chk("alu_op_hold", alu_op, op);
        sw = 3'($urandom);
        op_sw = 2'($urandom);
        repeat (3) @(negedge bbclk);
        press_step(bounce);
        chk("st_back_a", state, 0);
        chk("valid_clr", result_valid, 0);
        chk("result_clr", result, 0);
        chk("carry_clr", carry, 0);
        release_btn();
    endtask

    initial begin
        // Reset and idle with button released.
        repeat (2) @(negedge bbclk);
        rst_n = 1'b1;
        repeat (20) @(negedge bbclk);
        chk("rst_state", state, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_valid", result_valid, 0);

        // Bouncy press: single transition, no repeat while held.
        sw = 3'b110;
        n_trans = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge bbclk);
            btn_n = ~btn_n;
        end
        @(negedge bbclk);
        btn_n = 1'b0;
        repeat (10) @(negedge bbclk);
        chk("bounce_state", state, 1);
        chk("bounce_alu_a", alu_a, 6);
        repeat (50) @(negedge bbclk);
        chk("held_state", state, 1);
        chk("held_trans", n_trans, 1);
        release_btn();

        // Add with carry, then multiply where the stale core carry must be masked.
        apply_reset();
        run_op(7, 3, 2, 0, 0);
        chk("core_carry_set", alu_carry, 1);
        run_op(5, 6, 3, 2, 0);

        // Press injected during EXEC1 is dropped.
        run_op(4, 5, 2, 0, 1);

        // Reset during EXEC2 abandons the operation.
        apply_reset();
        sw = 3'd7; repeat (3) @(negedge bbclk); press_step(0); release_btn();
        sw = 3'd7; repeat (3) @(negedge bbclk); press_step(0); release_btn();
        op_sw = 2'b10; repeat (3) @(negedge bbclk); press_step(0);
        chk("mid_exec1", state, 3);
        @(negedge bbclk);
        chk("mid_exec2", state, 4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        @(negedge bbclk);
        btn_n = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge bbclk);
            chk("mid_no_valid", result_valid, 0);
        end
        chk("mid_post_state", state, 0);
        chk("mid_post_result", result, 0);

        // Randomized operations against the arithmetic model.
        for (int k = 0; k < 25; k++) begin
            run_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                   $urandom_range(0, 5), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
